// File: rtl/latch_mem_ctrl.sv
// latch_mem_ctrl: access sequencer for a latch-based memory array.
// One read requester and one write requester share the array. When both
// request at once, grants alternate round-robin.
// A read drives a one-hot read word line (RWL) for one cycle. The bench side
// returns DOUT from the read mux trees, and the controller captures it into
// RD_DATA, which holds until the response handshake.
// A write runs three cycles: setup (bit lines driven), pulse (one-hot WWL
// latch enable), and hold (bit lines held, WWL low).
// Ports:
//   CLK, RESETN                          clock, async active-low reset
//   RD_VALID/RD_READY/RD_ADDR            read request channel
//   RD_DATA_VALID/RD_DATA_READY/RD_DATA  read response channel
//   WR_VALID/WR_READY/WR_ADDR/WR_DATA    write request channel
//   RWL, WWL, WBL, DOUT                  array-side word lines, bit lines, read data
//   BUSY                                 high whenever not idle
module latch_mem_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              RD_VALID,
  output logic              RD_READY,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic              RD_DATA_VALID,
  input  logic              RD_DATA_READY,
  output logic [WIDTH-1:0]  RD_DATA,
  input  logic              WR_VALID,
  output logic              WR_READY,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [WIDTH-1:0]  WR_DATA,
  output logic [DEPTH-1:0]  RWL,
  output logic [DEPTH-1:0]  WWL,
  output logic [WIDTH-1:0]  WBL,
  input  logic [WIDTH-1:0]  DOUT,
  output logic              BUSY
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_DRIVE = 3'd1,
    RD_RESP  = 3'd2,
    WR_SETUP = 3'd3,
    WR_PULSE = 3'd4,
    WR_HOLD  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               last_wr_q, last_wr_d;
  logic [DEPTH-1:0]   rwl_q, rwl_d;
  logic [DEPTH-1:0]   wwl_q, wwl_d;
  logic [WIDTH-1:0]   wbl_q, wbl_d;
  logic [WIDTH-1:0]   rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_ready_s, wr_ready_s;

  // An address at or beyond DEPTH decodes to no row at all.
  function automatic logic [DEPTH-1:0] row_decode(input logic [ADDR_W-1:0] a);
    logic [DEPTH-1:0] dec;
    dec = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      dec[i] = (int'(a) == i);
    end
    return dec;
  endfunction

  // Next-state, arbitration and array-side output computation.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    last_wr_d  = last_wr_q;
    rwl_d      = rwl_q;
    wwl_d      = wwl_q;
    wbl_d      = wbl_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    rd_ready_s = 1'b0;
    wr_ready_s = 1'b0;
    case (state_q)
      IDLE: begin
        // last_wr_q picks the winner only when both requesters are valid.
        rd_ready_s = !WR_VALID || last_wr_q;
        wr_ready_s = !RD_VALID || !last_wr_q;
        if (RD_VALID && rd_ready_s) begin
          addr_d    = RD_ADDR;
          rwl_d     = row_decode(RD_ADDR);
          last_wr_d = 1'b0;
          state_d   = RD_DRIVE;
        end else if (WR_VALID && wr_ready_s) begin
          addr_d    = WR_ADDR;
          wbl_d     = WR_DATA;
          last_wr_d = 1'b1;
          state_d   = WR_SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      RD_DRIVE: begin
        // An out-of-range row drove no word line, so DOUT means nothing here.
        if (int'(addr_q) < DEPTH) begin
          rd_data_d = DOUT;
        end else begin
          rd_data_d = {WIDTH{1'b0}};
        end
        rwl_d      = {DEPTH{1'b0}};
        rd_valid_d = 1'b1;
        state_d    = RD_RESP;
      end
      RD_RESP: begin
        if (RD_DATA_READY) begin
          rd_valid_d = 1'b0;
          state_d    = IDLE;
        end else begin
          rd_valid_d = 1'b1;
        end
      end
      WR_SETUP: begin
        wwl_d   = row_decode(addr_q);
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        wwl_d   = {DEPTH{1'b0}};
        state_d = WR_HOLD;
      end
      WR_HOLD: begin
        state_d = IDLE;
      end
      default: begin
        rwl_d      = {DEPTH{1'b0}};
        wwl_d      = {DEPTH{1'b0}};
        rd_valid_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // State and registered-output flops.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= IDLE;
      addr_q     <= {ADDR_W{1'b0}};
      last_wr_q  <= 1'b1;
      rwl_q      <= {DEPTH{1'b0}};
      wwl_q      <= {DEPTH{1'b0}};
      wbl_q      <= {WIDTH{1'b0}};
      rd_data_q  <= {WIDTH{1'b0}};
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      last_wr_q  <= last_wr_d;
      rwl_q      <= rwl_d;
      wwl_q      <= wwl_d;
      wbl_q      <= wbl_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign RD_READY      = rd_ready_s;
  assign WR_READY      = wr_ready_s;
  assign RWL           = rwl_q;
  assign WWL           = wwl_q;
  assign WBL           = wbl_q;
  assign RD_DATA       = rd_data_q;
  assign RD_DATA_VALID = rd_valid_q;
  assign BUSY          = (state_q != IDLE);

endmodule

// File: tb/tb_latch_mem_ctrl.sv
// Directed bench for latch_mem_ctrl. It includes a latch-array model driven by
// WWL/WBL that returns DOUT from RWL. A shadow memory updated by the bench
// produces expected read data, which goes through a scoreboard queue.
module tb_latch_mem_ctrl;
  logic        CLK = 1'b0;
  logic        RESETN;
  logic        RD_VALID, RD_READY, RD_DATA_VALID, RD_DATA_READY;
  logic        WR_VALID, WR_READY, BUSY;
  logic [3:0]  RD_ADDR, WR_ADDR;
  logic [7:0]  RD_DATA, WR_DATA, WBL, DOUT;
  logic [15:0] RWL, WWL;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] mem [16];
  logic [7:0] ref_mem [16];
  logic [7:0] exp_q [$];

  latch_mem_ctrl #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) dut (
    .CLK(CLK), .RESETN(RESETN),
    .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_ADDR(RD_ADDR),
    .RD_DATA_VALID(RD_DATA_VALID), .RD_DATA_READY(RD_DATA_READY), .RD_DATA(RD_DATA),
    .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .RWL(RWL), .WWL(WWL), .WBL(WBL), .DOUT(DOUT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Latch array model: an open row follows the bit lines.
  always @(negedge CLK) begin
    for (int i = 0; i < 16; i++) begin
      if (WWL[i]) mem[i] <= WBL;
    end
  end

  // Read mux trees: OR of the rows selected by RWL.
  always_comb begin
    DOUT = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (RWL[i]) DOUT = DOUT | mem[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(RD_DATA), 32'(e));
    end
  endtask

  task automatic do_read(input logic [3:0] a, input int hold);
    logic [7:0] held;
    RD_VALID = 1'b1; RD_ADDR = a; RD_DATA_READY = 1'b0;
    #1;
    chk("rd_ready_idle", 32'(RD_READY), 32'd1);
    exp_q.push_back(ref_mem[a]);
    step();
    RD_VALID = 1'b0;
    chk("rwl_drive", 32'(RWL), 32'(16'h0001 << a));
    chk("rd_valid_early", 32'(RD_DATA_VALID), 32'd0);
    chk("busy_rd", 32'(BUSY), 32'd1);
    step();
    chk("rwl_cleared", 32'(RWL), 32'd0);
    chk("rd_valid", 32'(RD_DATA_VALID), 32'd1);
    pop_check("rd_data");
    held = RD_DATA;
    for (int c = 0; c < hold; c++) begin
      step();
      chk("hold_data", 32'(RD_DATA), 32'(held));
      chk("hold_valid", 32'(RD_DATA_VALID), 32'd1);
      chk("hold_readys", {30'd0, RD_READY, WR_READY}, 32'd0);
    end
    RD_DATA_READY = 1'b1;
    step();
    RD_DATA_READY = 1'b0;
    chk("rd_valid_drop", 32'(RD_DATA_VALID), 32'd0);
    chk("idle_after_rd", 32'(BUSY), 32'd0);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    WR_VALID = 1'b1; WR_ADDR = a; WR_DATA = d;
    #1;
    chk("wr_ready_idle", 32'(WR_READY), 32'd1);
    ref_mem[a] = d;
    step();
    WR_VALID = 1'b0;
    chk("setup_wbl", 32'(WBL), 32'(d));
    chk("setup_wwl", 32'(WWL), 32'd0);
    chk("busy_setup", 32'(BUSY), 32'd1);
    step();
    chk("pulse_wwl", 32'(WWL), 32'(16'h0001 << a));
    chk("pulse_wbl", 32'(WBL), 32'(d));
    step();
    chk("hold_wwl", 32'(WWL), 32'd0);
    chk("hold_wbl", 32'(WBL), 32'(d));
    chk("busy_hold", 32'(BUSY), 32'd1);
    step();
    chk("wr_idle", 32'(BUSY), 32'd0);
    chk("wbl_kept", 32'(WBL), 32'(d));
  endtask

  task automatic apply_reset();
    RESETN = 1'b0;
    #1;
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_lines", {RWL, WWL}, 32'd0);
    chk("rst_wbl", 32'(WBL), 32'd0);
    chk("rst_rdv", 32'(RD_DATA_VALID), 32'd0);
    chk("rst_rdata", 32'(RD_DATA), 32'd0);
    step();
    RESETN = 1'b1;
  endtask

  initial begin
    int grants;
    logic exp_wr;
    logic [7:0] prev_wbl;
    logic [7:0] wdat;
    RESETN = 1'b0; RD_VALID = 1'b0; WR_VALID = 1'b0; RD_DATA_READY = 1'b0;
    RD_ADDR = 4'd0; WR_ADDR = 4'd0; WR_DATA = 8'h00;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'(i * 17);
      ref_mem[i] = 8'(i * 17);
    end
    mem[5] = 8'hA5; ref_mem[5] = 8'hA5;
    mem[9] = 8'h11; ref_mem[9] = 8'h11;
    #2;
    apply_reset();
    chk("rst_readys", {30'd0, RD_READY, WR_READY}, 32'd3);

    // Single read, then a write, then a stalled read-back of the written row.
    do_read(4'd5, 0);
    do_write(4'd3, 8'h3C);
    do_read(4'd3, 5);

    // Last accept was a read; reset must still hand the first contended grant to the read.
    apply_reset();
    RD_VALID = 1'b1; WR_VALID = 1'b1; RD_ADDR = 4'd9; WR_ADDR = 4'd9;
    RD_DATA_READY = 1'b1; WR_DATA = 8'h40; wdat = 8'h40;
    exp_wr = 1'b0; grants = 0; prev_wbl = WBL;
    #1;
    for (int c = 0; c < 24; c++) begin
      if (RD_READY || WR_READY) begin
        chk("grant", {30'd0, RD_READY, WR_READY}, exp_wr ? 32'd1 : 32'd2);
        if (RD_READY) begin
          exp_q.push_back(ref_mem[9]);
        end else begin
          ref_mem[9] = WR_DATA;
        end
        exp_wr = !exp_wr;
        grants++;
      end
      step();
      if (WR_DATA != wdat) begin
        // no-op guard; WR_DATA only changes below
      end
      if (!BUSY) begin
        wdat = wdat + 8'h11;
        WR_DATA = wdat;
        #1;
      end
      if (RD_DATA_VALID) pop_check("cont_data");
      chk("no_overlap", 32'((RWL != 16'h0) && (WWL != 16'h0)), 32'd0);
      chk("onehot", 32'($countones(RWL) <= 1 && $countones(WWL) <= 1), 32'd1);
      chk("wwl_wbl_stable", 32'((WWL != 16'h0) && (WBL != prev_wbl)), 32'd0);
      prev_wbl = WBL;
    end
    chk("grant_count", 32'(grants >= 4), 32'd1);
    RD_VALID = 1'b0; WR_VALID = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (RD_DATA_VALID) pop_check("drain_data");
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    RD_DATA_READY = 1'b0;

    // Top row write followed by read-back.
    do_write(4'd15, 8'h77);
    do_read(4'd15, 0);

    // Reset in the middle of the write pulse, checked before any clock edge.
    WR_VALID = 1'b1; WR_ADDR = 4'd6; WR_DATA = 8'hE1;
    step();
    WR_VALID = 1'b0;
    step();
    chk("pulse_before_rst", 32'(WWL), 32'h0040);
    #2;
    RESETN = 1'b0;
    #1;
    chk("async_lines", {RWL, WWL}, 32'd0);
    chk("async_wbl", 32'(WBL), 32'd0);
    chk("async_busy_rdv", {30'd0, BUSY, RD_DATA_VALID}, 32'd0);
    step();
    RESETN = 1'b1;
    RD_VALID = 1'b1; WR_VALID = 1'b1; RD_ADDR = 4'd1; WR_ADDR = 4'd2;
    #1;
    chk("post_rst_grant", {30'd0, RD_READY, WR_READY}, 32'd2);
    RD_VALID = 1'b0; WR_VALID = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/latch_mem_ctrl.md
Name: latch_mem_ctrl

Overview:
Access sequencer for the 16-row latch memory array. It arbitrates one read requester and one write requester onto the array. For reads it drives the one-hot read word lines (RWL) into the per-bit read mux trees and captures DOUT. For writes it sequences write bit lines and a one-hot write word-line pulse with setup and hold cycles around the latch open window.

Parameters:
WIDTH, 8, data bits per row (one read mux instance per bit)
DEPTH, 16, number of rows; also width of the RWL and WWL buses
ADDR_W, 4, address width; must be at least clog2(DEPTH)

Ports:
CLK  in  1  clock, rising edge
RESETN  in  1  asynchronous active-low reset
RD_VALID  in  1  read request valid
RD_READY  out  1  read request accepted when RD_VALID & RD_READY at the clock edge
RD_ADDR  in  ADDR_W  read row address
RD_DATA_VALID  out  1  read response valid
RD_DATA_READY  in  1  read response consumed
RD_DATA  out  WIDTH  read response data
WR_VALID  in  1  write request valid
WR_READY  out  1  write request accepted when WR_VALID & WR_READY at the clock edge
WR_ADDR  in  ADDR_W  write row address
WR_DATA  in  WIDTH  write data
RWL  out  DEPTH  one-hot read word lines to the read mux trees
WWL  out  DEPTH  one-hot write word lines (latch enables)
WBL  out  WIDTH  write bit lines
DOUT  in  WIDTH  read mux outputs, one bit per mux tree
BUSY  out  1  high whenever state is not IDLE

Behaviour:
- Clocking and reset: single clock CLK. Reset is asynchronous, active-low RESETN.
- Reset values: RESETN low immediately forces the following, including mid-operation:
  - state = IDLE
  - RWL = 0, WWL = 0, WBL = 0, RD_DATA = 0
  - RD_DATA_VALID = 0, BUSY = 0
  - LAST_WR = 1, so the first contended grant goes to the read.
  - An aborted write leaves the row content undefined.
- States: IDLE, RD_DRIVE, RD_RESP, WR_SETUP, WR_PULSE, WR_HOLD. All outputs are registered except RD_READY, WR_READY and BUSY.
- Arbitration, IDLE only:
  - RD_READY = IDLE & (!WR_VALID | LAST_WR).
  - WR_READY = IDLE & (!RD_VALID | !LAST_WR).
  - Both are 0 in every other state.
  - With only one valid request, that request is granted. With both valid, grants alternate round-robin. LAST_WR updates only on an accept.
- Read sequence:
  - On accept, the address is registered. The next state is RD_DRIVE with RWL = 1<<RD_ADDR for exactly one cycle.
  - At the end of RD_DRIVE, DOUT is sampled into RD_DATA, RWL is cleared, and the state moves to RD_RESP with RD_DATA_VALID = 1.
  - RD_DATA and RD_DATA_VALID hold until RD_DATA_READY is high at a clock edge; then RD_DATA_VALID = 0 and the state returns to IDLE.
  - Accept-to-valid latency is 2 cycles; a read occupies at least 3 cycles including IDLE.
- Write sequence:
  - On accept, address and data are registered. WR_SETUP: WBL = data, WWL = 0.
  - WR_PULSE: WWL = 1<<WR_ADDR for exactly one cycle, WBL held.
  - WR_HOLD: WWL = 0, WBL held. Then IDLE.
  - WBL keeps its last value outside writes. A write occupies 4 cycles including IDLE.
- Invariants:
  - RWL and WWL each have at most one bit set.
  - RWL and WWL are never non-zero in the same cycle.
  - WWL is never set in the cycle in which WBL changes.
- Address out of range: an address >= DEPTH (possible only if DEPTH < 2^ADDR_W) produces all-zero word lines. The read returns RD_DATA = 0 and the sequence timing is unchanged.
- Ordering: transactions are serialized, so a read accepted after a write to the same row returns the new data.

Test Plan:
- Reset, then single read of addr 5 with DOUT driven 0xA5 -> RWL = 0x0020 for exactly 1 cycle; RD_DATA_VALID rises 2 cycles after accept with RD_DATA = 0xA5.
- Write addr 3 data 0x3C -> WBL = 0x3C one cycle before WWL = 0x0008 (1 cycle pulse) and one cycle after it; WBL stays 0x3C afterwards; BUSY high for 3 cycles.
- RD_VALID and WR_VALID held high continuously after reset -> grants read, write, read, write; RWL and WWL never overlap.
- RD_DATA_READY held low 5 cycles in RD_RESP -> RD_DATA stable, RD_DATA_VALID high, RD_READY = WR_READY = 0 throughout; IDLE the cycle after the ready handshake.
- Write 0x77 to addr 15, then read addr 15 with the DOUT model backed by the array -> RD_DATA = 0x77, RWL = 0x8000.
- RESETN asserted low during WR_PULSE -> WWL, RWL, WBL, RD_DATA_VALID and BUSY go to 0 without waiting for a clock edge; next contended grant after release goes to the read.
